// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing defaults, widths and the raster position type
// used by the video_timing block, its interface and its testbench.
package video_timing_pkg;

    // Counter and shift widths
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned SYNC_W  = 10;

    // Default raster: 384x264 total, 288x224 active, 6.144 MHz pixel rate
    localparam int unsigned DEF_CE_DIV       = 4;
    localparam int unsigned DEF_H_TOTAL      = 384;
    localparam int unsigned DEF_H_ACTIVE     = 288;
    localparam int unsigned DEF_H_SYNC_START = 304;
    localparam int unsigned DEF_H_SYNC_LEN   = 32;
    localparam int unsigned DEF_V_TOTAL      = 264;
    localparam int unsigned DEF_V_ACTIVE     = 224;
    localparam int unsigned DEF_V_SYNC_START = 240;
    localparam int unsigned DEF_V_SYNC_LEN   = 8;

    // Raster position pair
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
    } vpos_t;

    // Sign-extend a shift value into sync arithmetic width
    function automatic logic signed [SYNC_W-1:0] sext_shift(input logic [SHIFT_W-1:0] s);
        return {{(SYNC_W-SHIFT_W){s[SHIFT_W-1]}}, s};
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// video_timing_if: raster timing bundle from the timing generator to the
// game video logic and mixer.
//   master: the generator (drives timing, reads optional shifts)
//   slave : the consumer (reads timing, drives optional shifts)
// With VIDEO_TIMING_SHIFT_EN defined the h_shift/v_shift signals exist.
interface video_timing_if;
    import video_timing_pkg::*;

    logic               ce_pix;
    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               HSync;
    logic               VSync;
    logic               HBlank;
    logic               VBlank;
    logic               de;
    logic               frame_start;

`ifdef VIDEO_TIMING_SHIFT_EN
    logic [SHIFT_W-1:0] h_shift;
    logic [SHIFT_W-1:0] v_shift;

    modport master (
        output ce_pix, hcount, vcount, HSync, VSync, HBlank, VBlank, de, frame_start,
        input  h_shift, v_shift
    );
    modport slave (
        input  ce_pix, hcount, vcount, HSync, VSync, HBlank, VBlank, de, frame_start,
        output h_shift, v_shift
    );
`else
    modport master (
        output ce_pix, hcount, vcount, HSync, VSync, HBlank, VBlank, de, frame_start
    );
    modport slave (
        input  ce_pix, hcount, vcount, HSync, VSync, HBlank, VBlank, de, frame_start
    );
`endif

endinterface

// File: rtl/pix_ce_gen.sv
// pix_ce_gen: divides clk_sys into a one-cycle pixel clock-enable.
//   clk_sys : master clock
//   reset   : asynchronous active-high reset
//   ce_pix  : high for one clk_sys cycle every CE_DIV cycles, while the
//             divider count equals CE_DIV-1
module pix_ce_gen #(
    parameter int unsigned CE_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    output logic ce_pix
);

    localparam int unsigned DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    // ce_pix is registered one count early so it coincides with count CE_DIV-1
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            ce_pix  <= 1'b0;
        end else begin
            if (div_cnt == DIV_W'(CE_DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            ce_pix <= (div_cnt == DIV_W'(CE_DIV - 2));
        end
    end

endmodule

// File: rtl/video_timing.sv
// video_timing: raster timing generator feeding the video mixer.
//   clk_sys : master clock
//   reset   : asynchronous active-high reset
//   vid     : video_timing_if.master -- ce_pix, hcount, vcount, HSync, VSync,
//             HBlank, VBlank, de, frame_start (and h_shift/v_shift inputs
//             when VIDEO_TIMING_SHIFT_EN is defined)
// Every output except ce_pix is decoded from the next position and registered
// on the ce_pix edge, so decode always lines up with hcount/vcount.
// Optional feature macro: VIDEO_TIMING_SHIFT_EN (signed sync-position shifts,
// sampled once per frame on frame_start).
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned CE_DIV       = DEF_CE_DIV,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic           clk_sys,
    input  logic           reset,
    video_timing_if.master vid
);

    // Sync windows must stay inside blanking over the whole -8..+7 shift range
    if (CE_DIV < 4 || (CE_DIV % 2) != 0) begin : g_bad_ce_div
        $error("video_timing: CE_DIV must be even and at least 4");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("video_timing: totals exceed counter range");
    end
    if (H_SYNC_START < H_ACTIVE + 8 || H_SYNC_START + H_SYNC_LEN + 7 > H_TOTAL) begin : g_bad_hsync
        $error("video_timing: HSync window can leave horizontal blanking");
    end
    if (V_SYNC_START < V_ACTIVE + 8 || V_SYNC_START + V_SYNC_LEN + 7 > V_TOTAL) begin : g_bad_vsync
        $error("video_timing: VSync window can leave vertical blanking");
    end

    localparam logic signed [SYNC_W-1:0] H_SYNC_BASE = SYNC_W'(H_SYNC_START);
    localparam logic signed [SYNC_W-1:0] V_SYNC_BASE = SYNC_W'(V_SYNC_START);
    localparam logic signed [SYNC_W-1:0] H_SYNC_W    = SYNC_W'(H_SYNC_LEN);
    localparam logic signed [SYNC_W-1:0] V_SYNC_W    = SYNC_W'(V_SYNC_LEN);

    logic                     ce_pix;
    vpos_t                    pos_q;
    vpos_t                    pos_nxt;
    logic                     h_wrap;
    logic                     v_wrap;
    logic signed [SYNC_W-1:0] h_shift_eff;
    logic signed [SYNC_W-1:0] v_shift_eff;
    logic signed [SYNC_W-1:0] hs_start;
    logic signed [SYNC_W-1:0] hs_end;
    logic signed [SYNC_W-1:0] vs_start;
    logic signed [SYNC_W-1:0] vs_end;
    logic signed [SYNC_W-1:0] h_pos_s;
    logic signed [SYNC_W-1:0] v_pos_s;
    logic                     hsync_nxt;
    logic                     vsync_nxt;
    logic                     hblank_nxt;
    logic                     vblank_nxt;
    logic                     hsync_q;
    logic                     vsync_q;
    logic                     hblank_q;
    logic                     vblank_q;
    logic                     de_q;
    logic                     frame_start_q;

    pix_ce_gen #(
        .CE_DIV (CE_DIV)
    ) u_pix_ce_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix)
    );

`ifdef VIDEO_TIMING_SHIFT_EN
    logic [SHIFT_W-1:0] h_shadow;
    logic [SHIFT_W-1:0] v_shadow;

    // Shifts only take effect at a frame boundary so a frame is never torn
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            h_shadow <= '0;
            v_shadow <= '0;
        end else if (frame_start_q) begin
            h_shadow <= vid.h_shift;
            v_shadow <= vid.v_shift;
        end
    end

    assign h_shift_eff = sext_shift(h_shadow);
    assign v_shift_eff = sext_shift(v_shadow);
`else
    assign h_shift_eff = '0;
    assign v_shift_eff = '0;
`endif

    // Next raster position and its decode
    always_comb begin
        pos_nxt    = pos_q;
        h_wrap     = (pos_q.hcount == CNT_W'(H_TOTAL - 1));
        v_wrap     = (pos_q.vcount == CNT_W'(V_TOTAL - 1));
        if (h_wrap) begin
            pos_nxt.hcount = '0;
            pos_nxt.vcount = v_wrap ? '0 : pos_q.vcount + CNT_W'(1);
        end else begin
            pos_nxt.hcount = pos_q.hcount + CNT_W'(1);
        end

        hs_start   = H_SYNC_BASE + h_shift_eff;
        hs_end     = hs_start + H_SYNC_W;
        vs_start   = V_SYNC_BASE + v_shift_eff;
        vs_end     = vs_start + V_SYNC_W;
        h_pos_s    = $signed({1'b0, pos_nxt.hcount});
        v_pos_s    = $signed({1'b0, pos_nxt.vcount});

        hsync_nxt  = (h_pos_s >= hs_start) && (h_pos_s < hs_end);
        vsync_nxt  = (v_pos_s >= vs_start) && (v_pos_s < vs_end);
        hblank_nxt = (pos_nxt.hcount >= CNT_W'(H_ACTIVE));
        vblank_nxt = (pos_nxt.vcount >= CNT_W'(V_ACTIVE));
    end

    // Position and decoded outputs advance together on ce_pix
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pos_q         <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= ce_pix & h_wrap & v_wrap;
            if (ce_pix) begin
                pos_q    <= pos_nxt;
                hsync_q  <= hsync_nxt;
                vsync_q  <= vsync_nxt;
                hblank_q <= hblank_nxt;
                vblank_q <= vblank_nxt;
                de_q     <= ~hblank_nxt & ~vblank_nxt;
            end
        end
    end

    assign vid.ce_pix      = ce_pix;
    assign vid.hcount      = pos_q.hcount;
    assign vid.vcount      = pos_q.vcount;
    assign vid.HSync       = hsync_q;
    assign vid.VSync       = vsync_q;
    assign vid.HBlank      = hblank_q;
    assign vid.VBlank      = vblank_q;
    assign vid.de          = de_q;
    assign vid.frame_start = frame_start_q;

endmodule
